// File: rtl/prog_loader.sv
// Boot loader for the NAND CPU: receives a framed program over a byte stream,
// writes it to instruction memory, verifies the checksum and releases the core.
module prog_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned RUN_DELAY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_n_rst,
  input  logic              cpu_halt,
  output logic              loaded,
  output logic              halted,
  output logic              error
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned DLY_W = 4;

  typedef enum logic [2:0] {
    S_LEN, S_LOAD, S_CHECK, S_RELEASE, S_RUN, S_HALTED, S_ERROR
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_len, w_len_nxt;
  logic [CNT_W-1:0]  r_addr, w_addr_nxt;
  logic [7:0]        r_sum, w_sum_nxt;
  logic [DLY_W-1:0]  r_dly, w_dly_nxt;
  logic              r_s_ready, w_s_ready_nxt;
  logic              r_imem_we, w_imem_we_nxt;
  logic [ADDR_W-1:0] r_imem_addr, w_imem_addr_nxt;
  logic [7:0]        r_imem_wdata, w_imem_wdata_nxt;
  logic              r_cpu_n_rst, w_cpu_n_rst_nxt;
  logic              r_loaded, w_loaded_nxt;
  logic              r_halted, w_halted_nxt;
  logic              r_error, w_error_nxt;
  logic              w_acc;
  logic [8:0]        w_frame_len;

  assign w_acc       = s_valid & r_s_ready;
  // N==0 encodes a full-depth program; 9 bits covers 1..256 for any ADDR_W
  assign w_frame_len = (s_data == 8'd0) ? 9'(DEPTH) : {1'b0, s_data};

  // Next-state, datapath and next-output decode
  always_comb begin
    w_state_nxt      = r_state;
    w_len_nxt        = r_len;
    w_addr_nxt       = r_addr;
    w_sum_nxt        = r_sum;
    w_dly_nxt        = r_dly;
    w_imem_we_nxt    = 1'b0;
    w_imem_addr_nxt  = r_imem_addr;
    w_imem_wdata_nxt = r_imem_wdata;

    case (r_state)
      S_LEN: begin
        if (w_acc) begin
          if (w_frame_len > 9'(DEPTH)) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_len_nxt   = w_frame_len[CNT_W-1:0];
            w_addr_nxt  = '0;
            w_sum_nxt   = '0;
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (w_acc) begin
          w_imem_we_nxt    = 1'b1;
          w_imem_addr_nxt  = r_addr[ADDR_W-1:0];
          w_imem_wdata_nxt = s_data;
          w_sum_nxt        = r_sum + s_data;
          w_addr_nxt       = r_addr + CNT_W'(1);
          if (r_addr + CNT_W'(1) == r_len) begin
            w_state_nxt = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (w_acc) begin
          if (s_data == r_sum) begin
            w_dly_nxt   = DLY_W'(RUN_DELAY);
            w_state_nxt = S_RELEASE;
          end else begin
            w_state_nxt = S_ERROR;
          end
        end
      end
      S_RELEASE: begin
        if (r_dly <= DLY_W'(1)) begin
          w_dly_nxt   = '0;
          w_state_nxt = S_RUN;
        end else begin
          w_dly_nxt = r_dly - DLY_W'(1);
        end
      end
      S_RUN: begin
        if (cpu_halt) begin
          w_state_nxt = S_HALTED;
        end
      end
      S_HALTED, S_ERROR: begin
        if (restart) begin
          w_state_nxt = S_LEN;
        end
      end
      default: w_state_nxt = S_LEN;
    endcase

    // Status outputs are registered from the upcoming state
    w_s_ready_nxt   = (w_state_nxt == S_LEN) || (w_state_nxt == S_LOAD) ||
                      (w_state_nxt == S_CHECK);
    w_cpu_n_rst_nxt = (w_state_nxt == S_RUN);
    w_loaded_nxt    = (w_state_nxt == S_RUN) || (w_state_nxt == S_HALTED);
    w_halted_nxt    = (w_state_nxt == S_HALTED);
    w_error_nxt     = (w_state_nxt == S_ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_LEN;
      r_len        <= '0;
      r_addr       <= '0;
      r_sum        <= '0;
      r_dly        <= '0;
      r_s_ready    <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_cpu_n_rst  <= 1'b0;
      r_loaded     <= 1'b0;
      r_halted     <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_len        <= w_len_nxt;
      r_addr       <= w_addr_nxt;
      r_sum        <= w_sum_nxt;
      r_dly        <= w_dly_nxt;
      r_s_ready    <= w_s_ready_nxt;
      r_imem_we    <= w_imem_we_nxt;
      r_imem_addr  <= w_imem_addr_nxt;
      r_imem_wdata <= w_imem_wdata_nxt;
      r_cpu_n_rst  <= w_cpu_n_rst_nxt;
      r_loaded     <= w_loaded_nxt;
      r_halted     <= w_halted_nxt;
      r_error      <= w_error_nxt;
    end
  end

  assign s_ready    = r_s_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign cpu_n_rst  = r_cpu_n_rst;
  assign loaded     = r_loaded;
  assign halted     = r_halted;
  assign error      = r_error;

endmodule
